// File: rtl/shift_arbiter_32_if.sv
// Request/response/shifter bundle for shift_arbiter_32.
// slave = arbiter side, master = clients plus shifter side.
interface shift_arbiter_32_if;
   logic        req0_valid;
   logic        req1_valid;
   logic [31:0] req0_a;
   logic [31:0] req1_a;
   logic [4:0]  req0_sel;
   logic [4:0]  req1_sel;
   logic        req0_ready;
   logic        req1_ready;
   logic        resp0_valid;
   logic        resp1_valid;
   logic        resp0_ready;
   logic        resp1_ready;
   logic [31:0] resp_res;
   logic [31:0] shf_a;
   logic [4:0]  shf_sel;
   logic [31:0] shf_res;
   logic        busy;
   logic [15:0] op_count;

   modport slave (
      input  req0_valid, req1_valid, req0_a, req1_a,
      input  req0_sel, req1_sel, resp0_ready, resp1_ready,
      input  shf_res,
      output req0_ready, req1_ready, resp0_valid, resp1_valid,
      output resp_res, shf_a, shf_sel, busy, op_count
   );

   modport master (
      output req0_valid, req1_valid, req0_a, req1_a,
      output req0_sel, req1_sel, resp0_ready, resp1_ready,
      output shf_res,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid,
      input  resp_res, shf_a, shf_sel, busy, op_count
   );
endinterface

// File: rtl/shift_arbiter_32.sv
// Round-robin arbiter and sequencer for the shared 32-bit left shifter.
// Operands are registered onto the shifter; result captured after EXEC_WAIT.
module shift_arbiter_32 #(
   parameter int unsigned EXEC_WAIT = 1
) (
   input logic               clk,
   input logic               rst_n,
   shift_arbiter_32_if.slave bus
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

   localparam logic [3:0] WAIT_INIT = 4'(EXEC_WAIT - 1);

   state_e      state_q, state_d;
   logic        prio_q, prio_d;
   logic        owner_q, owner_d;
   logic [31:0] op_a_q, op_a_d;
   logic [4:0]  op_sel_q, op_sel_d;
   logic [31:0] res_q, res_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] op_count_q, op_count_d;
   logic        win;
   logic        req0_rdy, req1_rdy;
   logic        rsp0_vld, rsp1_vld;
   logic        own_ready;

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      owner_d    = owner_q;
      op_a_d     = op_a_q;
      op_sel_d   = op_sel_q;
      res_d      = res_q;
      cnt_d      = cnt_q;
      op_count_d = op_count_q;
      win        = 1'b0;
      req0_rdy   = 1'b0;
      req1_rdy   = 1'b0;
      rsp0_vld   = 1'b0;
      rsp1_vld   = 1'b0;
      own_ready  = owner_q ? bus.resp1_ready : bus.resp0_ready;
      unique case (state_q)
         IDLE: begin
            if (bus.req0_valid || bus.req1_valid) begin
               // contention resolved by prio, else the lone requester
               win = (bus.req0_valid && bus.req1_valid) ?
                     prio_q : bus.req1_valid;
               req0_rdy = ~win;
               req1_rdy = win;
               owner_d  = win;
               op_a_d   = win ? bus.req1_a : bus.req0_a;
               op_sel_d = win ? bus.req1_sel : bus.req0_sel;
               cnt_d    = WAIT_INIT;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               res_d   = bus.shf_res;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp0_vld = ~owner_q;
            rsp1_vld = owner_q;
            if (own_ready) begin
               state_d    = IDLE;
               prio_d     = ~owner_q;
               op_count_d = op_count_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         owner_q    <= 1'b0;
         op_a_q     <= 32'd0;
         op_sel_q   <= 5'd0;
         res_q      <= 32'd0;
         cnt_q      <= 4'd0;
         op_count_q <= 16'd0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         owner_q    <= owner_d;
         op_a_q     <= op_a_d;
         op_sel_q   <= op_sel_d;
         res_q      <= res_d;
         cnt_q      <= cnt_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus.req0_ready  = req0_rdy;
   assign bus.req1_ready  = req1_rdy;
   assign bus.resp0_valid = rsp0_vld;
   assign bus.resp1_valid = rsp1_vld;
   assign bus.resp_res    = res_q;
   assign bus.shf_a       = op_a_q;
   assign bus.shf_sel     = op_sel_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.op_count    = op_count_q;
endmodule

// File: tb/tb_shift_arbiter_32.sv
// Directed bench for shift_arbiter_32: EXEC_WAIT=1 and EXEC_WAIT=4 instances.
// b1 gets a behavioural shifter; b4's shifter output is driven by hand.
module tb_shift_arbiter_32;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   shift_arbiter_32_if b1 ();
   shift_arbiter_32_if b4 ();

   shift_arbiter_32 #(.EXEC_WAIT(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b1.slave)
   );

   shift_arbiter_32 #(.EXEC_WAIT(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (b4.slave)
   );

   assign b1.shf_res = b1.shf_a << b1.shf_sel;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One uncontended op on the EXEC_WAIT=1 instance, starting in IDLE.
   task automatic op1(input logic who, input logic [31:0] a,
                      input logic [4:0] sel, input logic [31:0] exp,
                      input logic [15:0] cnt);
      tick();
      if (who) begin
         b1.req1_valid = 1'b1; b1.req1_a = a; b1.req1_sel = sel;
      end else begin
         b1.req0_valid = 1'b1; b1.req0_a = a; b1.req0_sel = sel;
      end
      #1;
      chk("op_rdy", 32'(who ? b1.req1_ready : b1.req0_ready), 32'd1);
      tick();
      b1.req0_valid = 1'b0;
      b1.req1_valid = 1'b0;
      #1;
      chk("op_busy", 32'(b1.busy), 32'd1);
      chk("op_shf_a", b1.shf_a, a);
      tick();
      #1;
      chk("op_vld", 32'(who ? b1.resp1_valid : b1.resp0_valid), 32'd1);
      chk("op_res", b1.resp_res, exp);
      if (who) b1.resp1_ready = 1'b1;
      else b1.resp0_ready = 1'b1;
      tick();
      b1.resp0_ready = 1'b0;
      b1.resp1_ready = 1'b0;
      #1;
      chk("op_cnt", 32'(b1.op_count), 32'(cnt));
      chk("op_idle", 32'(b1.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1);
   end

   initial begin
      logic [31:0] early;
      logic [31:0] late;
      early = 32'hDEAD0001;
      late  = 32'hCAFE0004;
      b1.req0_valid = 0; b1.req1_valid = 0;
      b1.req0_a = 0; b1.req1_a = 0; b1.req0_sel = 0; b1.req1_sel = 0;
      b1.resp0_ready = 0; b1.resp1_ready = 0;
      b4.req0_valid = 0; b4.req1_valid = 0;
      b4.req0_a = 0; b4.req1_a = 0; b4.req0_sel = 0; b4.req1_sel = 0;
      b4.resp0_ready = 0; b4.resp1_ready = 0; b4.shf_res = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(b1.busy), 32'd0);
      chk("rst_rdy", 32'({b1.req0_ready, b1.req1_ready}), 32'd0);
      chk("rst_vld", 32'({b1.resp0_valid, b1.resp1_valid}), 32'd0);
      chk("rst_cnt", 32'(b1.op_count), 32'd0);
      chk("rst_shf_a", b1.shf_a, 32'd0);
      chk("rst_res", b1.resp_res, 32'd0);
      chk("rst4_busy", 32'(b4.busy), 32'd0);
      rst_n = 1'b1;

      // contention: req0 first (prio=0), then req1
      tick();
      b1.req0_valid = 1; b1.req0_a = 32'h0A000052; b1.req0_sel = 5'd1;
      b1.req1_valid = 1; b1.req1_a = 32'h00000001; b1.req1_sel = 5'd31;
      #1;
      chk("c_rdy0", 32'(b1.req0_ready), 32'd1);
      chk("c_rdy1", 32'(b1.req1_ready), 32'd0);
      tick();
      b1.req0_valid = 0;
      #1;
      chk("c_exec_rdy1", 32'(b1.req1_ready), 32'd0);
      tick();
      #1;
      chk("c_vld0", 32'(b1.resp0_valid), 32'd1);
      chk("c_vld1_lo", 32'(b1.resp1_valid), 32'd0);
      chk("c_res0", b1.resp_res, 32'h140000A4);
      b1.resp0_ready = 1;
      tick();
      b1.resp0_ready = 0;
      #1;
      chk("c_rdy1_next", 32'(b1.req1_ready), 32'd1);
      chk("c_rdy0_next", 32'(b1.req0_ready), 32'd0);
      tick();
      b1.req1_valid = 0;
      #1;
      tick();
      #1;
      chk("c_vld1", 32'(b1.resp1_valid), 32'd1);
      chk("c_vld0_lo", 32'(b1.resp0_valid), 32'd0);
      chk("c_res1", b1.resp_res, 32'h80000000);
      b1.resp1_ready = 1;
      tick();
      b1.resp1_ready = 0;
      #1;
      chk("c_cnt", 32'(b1.op_count), 32'd2);

      // backpressure; contention again, prio back to 0 so req0 wins
      tick();
      b1.req0_valid = 1; b1.req0_a = 32'h0C004638; b1.req0_sel = 5'd2;
      b1.req1_valid = 1; b1.req1_a = 32'h12345678; b1.req1_sel = 5'd0;
      #1;
      chk("bp_rdy0", 32'(b1.req0_ready), 32'd1);
      chk("bp_rdy1", 32'(b1.req1_ready), 32'd0);
      tick();
      b1.req0_valid = 0;
      #1;
      chk("bp_shf_a", b1.shf_a, 32'h0C004638);
      chk("bp_shf_sel", 32'(b1.shf_sel), 32'd2);
      chk("bp_lat", 32'(b1.resp0_valid), 32'd0);
      tick();
      #1;
      chk("bp_vld", 32'(b1.resp0_valid), 32'd1);
      chk("bp_res", b1.resp_res, 32'h300118E0);
      b1.resp1_ready = 1;
      repeat (5) begin
         tick();
         #1;
         chk("bp_hold_vld", 32'(b1.resp0_valid), 32'd1);
         chk("bp_hold_res", b1.resp_res, 32'h300118E0);
         chk("bp_hold_busy", 32'(b1.busy), 32'd1);
         chk("bp_hold_rdy1", 32'(b1.req1_ready), 32'd0);
      end
      b1.resp1_ready = 0;
      b1.resp0_ready = 1;
      tick();
      b1.resp0_ready = 0;
      #1;
      chk("bp_rdy1_after", 32'(b1.req1_ready), 32'd1);
      chk("bp_cnt", 32'(b1.op_count), 32'd3);
      tick();
      b1.req1_valid = 0;
      #1;
      tick();
      #1;
      chk("sel0_vld", 32'(b1.resp1_valid), 32'd1);
      chk("sel0_res", b1.resp_res, 32'h12345678);
      b1.resp1_ready = 1;
      tick();
      b1.resp1_ready = 0;
      #1;
      chk("sel0_cnt", 32'(b1.op_count), 32'd4);
      chk("idle_shf_a", b1.shf_a, 32'h12345678);

      // EXEC_WAIT=4: only the 4th EXEC cycle value is captured
      tick();
      b4.req0_valid = 1; b4.req0_a = 32'hFFFFFFFF; b4.req0_sel = 5'd4;
      #1;
      chk("w4_rdy", 32'(b4.req0_ready), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         b4.req0_valid = 0;
         b4.shf_res = (i == 4) ? late : early;
         #1;
         chk("w4_lat", 32'(b4.resp0_valid), 32'd0);
      end
      tick();
      b4.shf_res = 32'h0BAD0005;
      #1;
      chk("w4_vld", 32'(b4.resp0_valid), 32'd1);
      chk("w4_res", b4.resp_res, 32'hCAFE0004);
      chk("w4_shf_a", b4.shf_a, 32'hFFFFFFFF);
      chk("w4_shf_sel", 32'(b4.shf_sel), 32'd4);
      b4.resp0_ready = 1;
      tick();
      b4.resp0_ready = 0;
      #1;
      chk("w4_cnt", 32'(b4.op_count), 32'd1);

      // reset while dut4 is in EXEC
      tick();
      b4.req1_valid = 1; b4.req1_a = 32'h0000F00D; b4.req1_sel = 5'd8;
      #1;
      chk("mr_rdy", 32'(b4.req1_ready), 32'd1);
      tick();
      b4.req1_valid = 0;
      #1;
      chk("mr_busy", 32'(b4.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_busy0", 32'(b4.busy), 32'd0);
      chk("mr_shf_a", b4.shf_a, 32'd0);
      chk("mr_res", b4.resp_res, 32'd0);
      chk("mr_cnt4", 32'(b4.op_count), 32'd0);
      chk("mr_cnt1", 32'(b1.op_count), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      repeat (6) begin
         tick();
         #1;
         chk("mr_stale", 32'({b4.resp0_valid, b4.resp1_valid}), 32'd0);
      end
      chk("mr_cnt_after", 32'(b4.op_count), 32'd0);

      // prio reset to 0: contended op goes to req0; sel=31 keeps bit 0
      tick();
      b1.req0_valid = 1; b1.req0_a = 32'h00000003; b1.req0_sel = 5'd31;
      b1.req1_valid = 1; b1.req1_a = 32'h00000005; b1.req1_sel = 5'd1;
      #1;
      chk("pr_rdy0", 32'(b1.req0_ready), 32'd1);
      chk("pr_rdy1", 32'(b1.req1_ready), 32'd0);
      tick();
      b1.req0_valid = 0;
      b1.req1_valid = 0;
      #1;
      tick();
      #1;
      chk("pr_vld0", 32'(b1.resp0_valid), 32'd1);
      chk("pr_res", b1.resp_res, 32'h80000000);
      b1.resp0_ready = 1;
      tick();
      b1.resp0_ready = 0;
      #1;
      chk("pr_cnt", 32'(b1.op_count), 32'd1);

      op1(1'b0, 32'h0C004638, 5'd2, 32'h300118E0, 16'd2);

      // wrap: preload the counter just below the boundary
      force dut1.op_count_q = 16'hFFFF;
      #1;
      release dut1.op_count_q;
      #1;
      chk("wrap_pre", 32'(b1.op_count), 32'h0000FFFF);
      op1(1'b1, 32'h00000001, 5'd31, 32'h80000000, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
